// File: rtl/lwb_fabric.sv
// lwb_fabric: table-driven Wishbone interconnect with bus-timeout watchdog, unmapped-address
// error response, sticky fault capture and interrupt-vector acknowledge.
// Ports: lwb_clkp/wb_rst_i (async active-high); m_* CPU master side; s_stb_o/s_ack_i/s_dat_i
// per-slave strobes, acks and packed read data; istb_i/iack_o vector handshake;
// flt_clr_i clears, flt_* report the first fault since clear plus a saturating count.
module lwb_fabric #(
    parameter int NSLV = 8,
    parameter int AW = 16,
    parameter int DW = 16,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
    parameter int TMO = 63
) (
    input  logic             lwb_clkp,
    input  logic             wb_rst_i,
    input  logic [AW-1:0]    m_adr_i,
    input  logic             m_cyc_i,
    input  logic             m_stb_i,
    input  logic             m_we_i,
    output logic [DW-1:0]    m_dat_o,
    output logic             m_ack_o,
    output logic             m_err_o,
    output logic [NSLV-1:0]  s_stb_o,
    input  logic [NSLV-1:0]  s_ack_i,
    input  logic [NSLV*DW-1:0] s_dat_i,
    input  logic             istb_i,
    output logic             iack_o,
    input  logic             flt_clr_i,
    output logic             flt_valid_o,
    output logic [AW-1:0]    flt_adr_o,
    output logic             flt_we_o,
    output logic             flt_tmo_o,
    output logic [7:0]       flt_cnt_o
);
    typedef enum logic [1:0] {IDLE, WAIT, FAULT_ACK, HOLD} state_t;
    state_t state, nxt;
    logic [7:0] cnt, cnt_n;
    logic req, ack_sel, cause_tmo, cause_n;
    logic [NSLV-1:0] hit, sel;

    assign req = m_cyc_i & m_stb_i;

    always_comb begin
        hit = '0;
        sel = '0;
        m_dat_o = '0;
        for (int i = 0; i < NSLV; i++)
            hit[i] = req & ((m_adr_i & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]));
        // Scan downward so the lowest matching index is the one left standing.
        for (int i = NSLV - 1; i >= 0; i--)
            if (hit[i]) begin
                sel = '0;
                sel[i] = 1'b1;
            end
        for (int i = 0; i < NSLV; i++)
            if (sel[i]) m_dat_o = s_dat_i[i*DW +: DW];
        ack_sel = |(s_ack_i & sel);
    end

    // Decode stays live in HOLD so a held slave ack still reaches the master,
    // but no new strobe is issued once the transfer has been answered.
    assign s_stb_o = (state == IDLE || state == WAIT) ? sel : '0;
    assign m_ack_o = ack_sel | (state == FAULT_ACK);
    assign m_err_o = state == FAULT_ACK;

    always_comb begin
        nxt = state;
        cnt_n = '0;
        cause_n = cause_tmo;
        case (state)
            IDLE:
                if (req) begin
                    if (!(|hit)) begin
                        nxt = FAULT_ACK;
                        cause_n = 1'b0;
                    end else begin
                        nxt = ack_sel ? HOLD : WAIT;
                    end
                end
            WAIT:
                // Ack is tested before the timeout so a last-moment ack still wins.
                if (ack_sel) nxt = HOLD;
                else if (!req) nxt = IDLE;
                else if (cnt == 8'(TMO - 1)) begin
                    nxt = FAULT_ACK;
                    cause_n = 1'b1;
                end else cnt_n = cnt + 8'd1;
            FAULT_ACK: nxt = HOLD;
            HOLD: nxt = req ? HOLD : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge lwb_clkp or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt <= '0;
            cause_tmo <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= cnt_n;
            cause_tmo <= cause_n;
        end
    end

    // The master still holds address and direction during FAULT_ACK, so they are captured then.
    always_ff @(posedge lwb_clkp or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            iack_o <= 1'b0;
            flt_valid_o <= 1'b0;
            flt_adr_o <= '0;
            flt_we_o <= 1'b0;
            flt_tmo_o <= 1'b0;
            flt_cnt_o <= '0;
        end else begin
            iack_o <= istb_i & ~iack_o;
            if (state == FAULT_ACK) begin
                flt_valid_o <= 1'b1;
                flt_cnt_o <= flt_clr_i ? 8'd1 : flt_cnt_o + 8'(flt_cnt_o != 8'hff);
                if (!flt_valid_o || flt_clr_i) begin
                    flt_adr_o <= m_adr_i;
                    flt_we_o <= m_we_i;
                    flt_tmo_o <= cause_tmo;
                end
            end else if (flt_clr_i) begin
                flt_valid_o <= 1'b0;
                flt_cnt_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_lwb_fabric.sv
// tb_lwb_fabric: randomized scoreboard bench for lwb_fabric against a transaction-level model.
module tb_lwb_fabric;
    localparam int TMO = 8;
    localparam int NEVER = 1000;
    localparam logic [15:0] BASES [4] = '{16'o000000, 16'o010000, 16'o024000, 16'o024000};
    localparam logic [15:0] MASKS [4] = '{16'o170000, 16'o170000, 16'o177760, 16'o177700};

    logic clk = 0, rst = 1;
    logic [15:0] m_adr_i = 0;
    logic m_cyc_i = 0, m_stb_i = 0, m_we_i = 0, istb_i = 0, flt_clr_i = 0;
    logic [3:0] s_ack_i = 0;
    logic [63:0] s_dat_i = 0;
    logic [15:0] m_dat_o, flt_adr_o;
    logic m_ack_o, m_err_o, iack_o, flt_valid_o, flt_we_o, flt_tmo_o;
    logic [3:0] s_stb_o;
    logic [7:0] flt_cnt_o;

    lwb_fabric #(
        .NSLV(4), .AW(16), .DW(16),
        .SLV_BASE({16'o024000, 16'o024000, 16'o010000, 16'o000000}),
        .SLV_MASK({16'o177700, 16'o177760, 16'o170000, 16'o170000}),
        .TMO(TMO)
    ) dut (
        .lwb_clkp(clk), .wb_rst_i(rst), .m_adr_i(m_adr_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_we_i(m_we_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_stb_o(s_stb_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .istb_i(istb_i), .iack_o(iack_o), .flt_clr_i(flt_clr_i),
        .flt_valid_o(flt_valid_o), .flt_adr_o(flt_adr_o), .flt_we_o(flt_we_o), .flt_tmo_o(flt_tmo_o),
        .flt_cnt_o(flt_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; bit err; logic [15:0] dat;} exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, tcyc = -1;
    bit fvalid = 0, fwe = 0, ftmo = 0;
    logic [15:0] fadr = 0;
    int fcnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(logic [15:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASKS[i]) == (BASES[i] & MASKS[i])) return i;
        return -1;
    endfunction

    task automatic chk_flt();
        chk("flt_valid", 32'(flt_valid_o), 32'(fvalid));
        chk("flt_cnt", 32'(flt_cnt_o), 32'(fcnt));
        if (fvalid) begin
            chk("flt_adr", 32'(flt_adr_o), 32'(fadr));
            chk("flt_we", 32'(flt_we_o), 32'(fwe));
            chk("flt_tmo", 32'(flt_tmo_o), 32'(ftmo));
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_ack_o) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack err=%0b cycle=%0d expected none", m_err_o, tcyc);
                end else begin
                    e = q.pop_front();
                    chk("ack_cycle", 32'(tcyc), 32'(e.cyc));
                    chk("ack_err", 32'(m_err_o), 32'(e.err));
                    if (!e.err) chk("ack_data", 32'(m_dat_o), 32'(e.dat));
                end
            end
        end
    end

    task automatic run_txn(logic [15:0] adr, bit we, int d, int abort_k, bit clr);
        int idx, resp, last, lim;
        bit err, fault;
        exp_t e;
        logic [3:0] own, noise;
        idx = lookup(adr);
        s_dat_i = {$urandom, $urandom};
        if (idx < 0) begin resp = 1; err = 1; end
        else if (d <= TMO) begin resp = d; err = 0; end
        else begin resp = TMO + 1; err = 1; end
        lim = (d < TMO) ? d : TMO;
        last = abort_k != 0 ? abort_k - 1 : resp;
        if (abort_k == 0) begin
            e.cyc = resp;
            e.err = err;
            e.dat = idx >= 0 ? s_dat_i[idx*16 +: 16] : 16'h0;
            q.push_back(e);
        end
        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            tcyc = c;
            m_cyc_i = 1;
            m_stb_i = 1;
            m_adr_i = adr;
            m_we_i = we;
            own = (idx >= 0 && c >= d) ? 4'(1 << idx) : 4'h0;
            noise = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            if (idx >= 0) noise = noise & ~4'(1 << idx);
            s_ack_i = own | noise;
            flt_clr_i = clr && c == last;
            @(negedge clk);
            chk("s_stb", 32'(s_stb_o), (idx >= 0 && c <= lim) ? 32'(1 << idx) : 32'h0);
        end
        @(posedge clk);
        #1;
        tcyc = -1;
        m_cyc_i = 0;
        m_stb_i = 0;
        s_ack_i = 0;
        flt_clr_i = 0;
        fault = abort_k == 0 && err;
        if (fault) begin
            fcnt = clr ? 1 : (fcnt == 255 ? 255 : fcnt + 1);
            if (!fvalid || clr) begin fadr = adr; fwe = we; ftmo = idx >= 0; end
            fvalid = 1;
        end else if (clr) begin
            fvalid = 0;
            fcnt = 0;
        end
        @(negedge clk);
        chk("idle_stb", 32'(s_stb_o), 32'h0);
        chk_flt();
    endtask

    initial begin
        logic [15:0] adr;
        int idx, d, k, lim;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ack", 32'(m_ack_o), 32'h0);
        chk("rst_err", 32'(m_err_o), 32'h0);
        chk("rst_iack", 32'(iack_o), 32'h0);
        chk("rst_stb", 32'(s_stb_o), 32'h0);
        chk_flt();
        chk("rst_adr", 32'(flt_adr_o), 32'h0);

        run_txn(16'o024006, 0, 2, 0, 0);
        run_txn(16'o177776, 0, NEVER, 0, 0);
        run_txn(16'o010004, 1, NEVER, 0, 1);
        run_txn(16'o010100, 1, NEVER, 0, 0);
        run_txn(16'o000010, 0, TMO, 0, 0);
        run_txn(16'o000020, 1, TMO + 1, 0, 0);
        run_txn(16'o010000, 0, NEVER, 3, 0);
        run_txn(16'o024030, 0, 0, 0, 0);

        @(posedge clk);
        #1 istb_i = 1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) istb_i = 0;
            @(negedge clk);
            chk("iack_seq", 32'(iack_o), 32'(i % 2));
        end

        istb_i = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            m_cyc_i = 1;
            m_stb_i = 1;
            m_adr_i = 16'o010200;
            m_we_i = 0;
        end
        #2 rst = 1;
        #1;
        chk("arst_valid", 32'(flt_valid_o), 32'h0);
        chk("arst_cnt", 32'(flt_cnt_o), 32'h0);
        chk("arst_adr", 32'(flt_adr_o), 32'h0);
        chk("arst_iack", 32'(iack_o), 32'h0);
        chk("arst_err", 32'(m_err_o), 32'h0);
        chk("arst_ack", 32'(m_ack_o), 32'h0);
        m_cyc_i = 0;
        m_stb_i = 0;
        istb_i = 0;
        fvalid = 0; fcnt = 0; fadr = 0; fwe = 0; ftmo = 0;
        @(posedge clk);
        #1 rst = 0;

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: adr = 16'($urandom_range(0, 16'o7777));
                1: adr = 16'o010000 | 16'($urandom_range(0, 16'o7777));
                2: adr = 16'o024000 + 16'($urandom_range(0, 15));
                3: adr = 16'o024020 + 16'($urandom_range(0, 16'o57));
                4: adr = 16'o020000 + 16'($urandom_range(0, 16'o3777));
                default: adr = 16'o177776;
            endcase
            idx = lookup(adr);
            d = $urandom_range(0, 4) == 0 ? NEVER : int'($urandom_range(0, TMO + 2));
            lim = d < TMO ? d : TMO;
            k = (idx >= 0 && lim >= 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, lim)) : 0;
            run_txn(adr, 1'($urandom), d, k, $urandom_range(0, 7) == 0);
        end

        for (int n = 0; n < 260; n++) run_txn(16'o177776, 1'($urandom), NEVER, 0, 0);
        run_txn(16'o177776, 0, NEVER, 0, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
